// File: rtl/escalonador_rr.sv
// -----------------------------------------------------------------------------
// escalonador_rr
//   Round-robin process scheduler for the multiprogrammed CPU. Keeps a table
//   of saved PCs for NUM_PROC user program slots and enables the preemption
//   timer while a user process runs. On a quantum expiry (timer rising edge)
//   or a process exit it performs a context switch: save pc_atual (on expiry
//   only), select the next live slot in round-robin order and hand its PC to
//   the CPU through a switch_req/switch_ack handshake. When no live slot is
//   left, os_return pulses and the scheduler goes back to IDLE.
//
// Ports
//   clock_auto  in   system clock, rising edge
//   reset_n     in   asynchronous reset, active low
//   start       in   1-cycle pulse from the OS, honoured in IDLE only
//   proc_valid  in   per-slot "program loaded" flags, sampled on start
//   proc_entry  in   packed entry PCs, slot i = [32*i+31:32*i], sampled on start
//   timer       in   quantum-expiry level from the timer block
//   proc_exit   in   1-cycle pulse, running process executed its exit
//   pc_atual    in   current CPU PC
//   switch_ack  in   CPU has taken pc_novo
//   switch_req  out  request for the CPU to jump to pc_novo
//   pc_novo     out  PC being dispatched, held stable during the handshake
//   proc_atual  out  index of the current / last dispatched slot
//   preempcao   out  32'd1 while a process runs, else 32'd0 (timer enable)
//   os_return   out  1-cycle pulse when no live slots remain
//   busy        out  high in every state except IDLE
// -----------------------------------------------------------------------------
module escalonador_rr #(
  parameter int          NUM_PROC     = 4,
  parameter int          IDX_W        = 2,
  parameter logic [31:0] PC_USER_BASE = 32'd3000
) (
  input  logic                  clock_auto,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [NUM_PROC-1:0]   proc_valid,
  input  logic [NUM_PROC*32-1:0] proc_entry,
  input  logic                  timer,
  input  logic                  proc_exit,
  input  logic [31:0]           pc_atual,
  input  logic                  switch_ack,
  output logic                  switch_req,
  output logic [31:0]           pc_novo,
  output logic [IDX_W-1:0]      proc_atual,
  output logic [31:0]           preempcao,
  output logic                  os_return,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    PICK,
    DISPATCH,
    RUN
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PROC - 1);

  state_t              state;
  logic [31:0]         pc_tab [NUM_PROC];
  logic [NUM_PROC-1:0] finished;
  logic [IDX_W-1:0]    cur;
  logic                pend;
  logic                timer_q;

  logic                tick;
  logic                user_pc;
  logic [IDX_W-1:0]    probe;
  logic [IDX_W-1:0]    next_idx;
  logic                next_found;

  // Only a rising edge of the timer level counts as a quantum expiry.
  assign tick    = timer & ~timer_q;
  assign user_pc = (pc_atual >= PC_USER_BASE);

  // Round-robin search starting after cur. The probe walks with an explicit
  // wrap so NUM_PROC need not be a power of two; after NUM_PROC steps it lands
  // back on cur, so the current slot is considered last.
  always_comb begin
    probe      = cur;
    next_idx   = cur;
    next_found = 1'b0;
    for (int k = 0; k < NUM_PROC; k++) begin
      probe = (probe == LAST_IDX) ? '0 : probe + 1'b1;
      if (!next_found && !finished[probe]) begin
        next_idx   = probe;
        next_found = 1'b1;
      end
    end
  end

  // Scheduler FSM with registered outputs. Outputs are updated on the same
  // edge as the state transition so they always agree with the state.
  always_ff @(posedge clock_auto or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      switch_req <= 1'b0;
      pc_novo    <= '0;
      proc_atual <= '0;
      preempcao  <= '0;
      os_return  <= 1'b0;
      busy       <= 1'b0;
      finished   <= '0;
      cur        <= '0;
      pend       <= 1'b0;
      timer_q    <= 1'b0;
      for (int i = 0; i < NUM_PROC; i++) begin
        pc_tab[i] <= '0;
      end
    end else begin
      timer_q   <= timer;
      os_return <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < NUM_PROC; i++) begin
              pc_tab[i] <= proc_entry[32*i +: 32];
            end
            // Slots without a program are treated as already finished.
            finished <= ~proc_valid;
            // Starting from the last slot makes the first search begin at 0.
            cur      <= LAST_IDX;
            pend     <= 1'b0;
            busy     <= 1'b1;
            state    <= PICK;
          end
        end

        PICK: begin
          if (next_found) begin
            cur        <= next_idx;
            pc_novo    <= pc_tab[next_idx];
            proc_atual <= next_idx;
            switch_req <= 1'b1;
            state      <= DISPATCH;
          end else begin
            os_return <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end

        DISPATCH: begin
          if (switch_ack) begin
            switch_req <= 1'b0;
            preempcao  <= 32'd1;
            state      <= RUN;
          end
        end

        RUN: begin
          if (proc_exit) begin
            // Exit wins over a coincident expiry; the slot's PC is not saved.
            finished[cur] <= 1'b1;
            pend          <= 1'b0;
            preempcao     <= '0;
            state         <= PICK;
          end else if ((tick | pend) && user_pc) begin
            pc_tab[cur] <= pc_atual;
            pend        <= 1'b0;
            preempcao   <= '0;
            state       <= PICK;
          end else if (tick) begin
            // The OS is servicing something below the user base; remember the
            // expiry and switch as soon as control is back in user code.
            pend <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_escalonador_rr.sv
// -----------------------------------------------------------------------------
// tb_escalonador_rr
//   Self-checking bench for escalonador_rr. Directed scenarios use values taken
//   straight from the scheduler's rules; the randomized scenario is checked
//   against an event-level round-robin model kept in this file.
// -----------------------------------------------------------------------------
module tb_escalonador_rr;

  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'd3000;

  logic             clock_auto = 1'b0;
  logic             reset_n    = 1'b0;
  logic             start      = 1'b0;
  logic [N-1:0]     proc_valid = '0;
  logic [N*32-1:0]  proc_entry = '0;
  logic             timer      = 1'b0;
  logic             proc_exit  = 1'b0;
  logic [31:0]      pc_atual   = '0;
  logic             switch_ack = 1'b0;
  logic             switch_req;
  logic [31:0]      pc_novo;
  logic [1:0]       proc_atual;
  logic [31:0]      preempcao;
  logic             os_return;
  logic             busy;

  int vectors     = 0;
  int miscompares = 0;

  escalonador_rr #(.NUM_PROC(N), .IDX_W(2), .PC_USER_BASE(BASE)) dut (
    .clock_auto (clock_auto),
    .reset_n    (reset_n),
    .start      (start),
    .proc_valid (proc_valid),
    .proc_entry (proc_entry),
    .timer      (timer),
    .proc_exit  (proc_exit),
    .pc_atual   (pc_atual),
    .switch_ack (switch_ack),
    .switch_req (switch_req),
    .pc_novo    (pc_novo),
    .proc_atual (proc_atual),
    .preempcao  (preempcao),
    .os_return  (os_return),
    .busy       (busy)
  );

  always #5 clock_auto = ~clock_auto;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- reference model (event level) ----------------
  bit          m_fin [N];
  logic [31:0] m_pc  [N];
  int          m_cur;
  bit          m_pend;
  int          exp_kind;   // 0 keep running, 1 dispatch, 2 return to OS
  logic [31:0] exp_pc;
  int          exp_idx;

  task automatic model_pick();
    exp_kind = 2;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_cur + k) % N;
      if (exp_kind == 2 && !m_fin[j]) begin
        exp_kind = 1;
        exp_idx  = j;
        exp_pc   = m_pc[j];
      end
    end
    if (exp_kind == 1) m_cur = exp_idx;
  endtask

  task automatic model_start(input logic [N-1:0] v, input logic [N*32-1:0] e);
    for (int i = 0; i < N; i++) begin
      m_fin[i] = !v[i];
      m_pc[i]  = e[32*i +: 32];
    end
    m_cur  = N - 1;
    m_pend = 1'b0;
    model_pick();
  endtask

  task automatic model_event(input logic [31:0] pc, input bit tk, input bit ex);
    if (ex) begin
      m_fin[m_cur] = 1'b1;
      m_pend = 1'b0;
      model_pick();
    end else if ((tk || m_pend) && pc >= BASE) begin
      m_pc[m_cur] = pc;
      m_pend = 1'b0;
      model_pick();
    end else begin
      if (tk) m_pend = 1'b1;
      exp_kind = 0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clock_auto);
    #1;
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    start      = 1'b0;
    timer      = 1'b0;
    proc_exit  = 1'b0;
    switch_ack = 1'b0;
    pc_atual   = '0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  // Start pulse, then the PICK cycle; returns sampled just after PICK resolves.
  task automatic drive_start(input logic [N-1:0] v, input logic [N*32-1:0] e);
    proc_valid = v;
    proc_entry = e;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
  endtask

  // One RUN cycle of stimulus followed by one quiet cycle, so a switch has
  // already passed through PICK when the caller samples.
  task automatic drive_event(input logic [31:0] pc, input bit tk, input bit ex);
    pc_atual  = pc;
    timer     = tk;
    proc_exit = ex;
    step();
    timer     = 1'b0;
    proc_exit = 1'b0;
    step();
  endtask

  // Holds ack low for 'delay' cycles, counting cycles where the request was
  // not held with the wanted PC, then acknowledges.
  task automatic drive_ack(input int delay, input logic [31:0] want, output int bad);
    bad = 0;
    repeat (delay) begin
      switch_ack = 1'b0;
      step();
      if (switch_req !== 1'b1 || pc_novo !== want) bad++;
    end
    switch_ack = 1'b1;
    step();
    switch_ack = 1'b0;
  endtask

  function automatic logic [N*32-1:0] pack4(input logic [31:0] e0, input logic [31:0] e1,
                                            input logic [31:0] e2, input logic [31:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    vectors++;
    if ({switch_req, os_return, busy} !== 3'b000 || proc_atual !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: req/osr/busy=%b idx=%0d want 000/0",
               {switch_req, os_return, busy}, proc_atual);
    end
    vectors++;
    if (pc_novo !== 32'd0 || preempcao !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: pc_novo=%0d preempcao=%0d want 0/0", pc_novo, preempcao);
    end
    do_reset();
  endtask

  task automatic test_dispatch();
    int bad;
    do_reset();
    proc_valid = 4'b0101;
    proc_entry = pack4(32'd3000, 32'd0, 32'd5000, 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || switch_req !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL pick_cycle: busy=%b req=%b want 1/0", busy, switch_req);
    end
    step();
    vectors++;
    if (switch_req !== 1'b1 || pc_novo !== 32'd3000 || proc_atual !== 2'd0 || preempcao !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL first_dispatch: req=%b pc=%0d idx=%0d pre=%0d want 1/3000/0/0",
               switch_req, pc_novo, proc_atual, preempcao);
    end
    drive_ack(3, 32'd3000, bad);
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("[TB] FAIL dispatch_hold: %0d unstable cycles want 0", bad);
    end
    vectors++;
    if (switch_req !== 1'b0 || preempcao !== 32'd1 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL enter_run: req=%b pre=%0d busy=%b want 0/1/1", switch_req, preempcao, busy);
    end
  endtask

  task automatic test_preempt();
    int bad;
    do_reset();
    drive_start(4'b0101, pack4(32'd3000, 32'd0, 32'd5000, 32'd0));
    drive_ack(0, 32'd3000, bad);
    drive_event(32'd3124, 1'b1, 1'b0);
    vectors++;
    if (switch_req !== 1'b1 || pc_novo !== 32'd5000 || proc_atual !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL preempt_to_2: req=%b pc=%0d idx=%0d want 1/5000/2", switch_req, pc_novo, proc_atual);
    end
    // Timer already high before RUN: the held level must not count as a tick.
    timer    = 1'b1;
    pc_atual = 32'd5040;
    drive_ack(1, 32'd5000, bad);
    repeat (3) step();
    vectors++;
    if (switch_req !== 1'b0 || preempcao !== 32'd1) begin
      miscompares++;
      $display("[TB] FAIL held_level: req=%b pre=%0d want 0/1", switch_req, preempcao);
    end
    timer = 1'b0;
    step();
    drive_event(32'd5040, 1'b1, 1'b0);
    vectors++;
    if (switch_req !== 1'b1 || pc_novo !== 32'd3124 || proc_atual !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL preempt_to_0: req=%b pc=%0d idx=%0d want 1/3124/0", switch_req, pc_novo, proc_atual);
    end
  endtask

  task automatic test_pending();
    int bad;
    do_reset();
    drive_start(4'b0101, pack4(32'd3000, 32'd0, 32'd5000, 32'd0));
    drive_ack(0, 32'd3000, bad);
    drive_event(32'd2990, 1'b1, 1'b0);
    // A start pulse outside IDLE must have no effect.
    proc_valid = 4'b1111;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    vectors++;
    if (switch_req !== 1'b0 || preempcao !== 32'd1) begin
      miscompares++;
      $display("[TB] FAIL pend_hold: req=%b pre=%0d want 0/1", switch_req, preempcao);
    end
    pc_atual = 32'd3000;
    step();
    step();
    vectors++;
    if (switch_req !== 1'b1 || pc_novo !== 32'd5000 || proc_atual !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL pend_switch: req=%b pc=%0d idx=%0d want 1/5000/2", switch_req, pc_novo, proc_atual);
    end
    drive_ack(0, 32'd5000, bad);
    drive_event(32'd5100, 1'b1, 1'b0);
    vectors++;
    if (switch_req !== 1'b1 || pc_novo !== 32'd3000 || proc_atual !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL pend_saved: req=%b pc=%0d idx=%0d want 1/3000/0", switch_req, pc_novo, proc_atual);
    end
  endtask

  task automatic test_exit();
    int bad;
    do_reset();
    drive_start(4'b0101, pack4(32'd3000, 32'd0, 32'd5000, 32'd0));
    drive_ack(0, 32'd3000, bad);
    drive_event(32'd3500, 1'b1, 1'b1);
    vectors++;
    if (switch_req !== 1'b1 || pc_novo !== 32'd5000 || proc_atual !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL exit_tick: req=%b pc=%0d idx=%0d want 1/5000/2", switch_req, pc_novo, proc_atual);
    end
    drive_ack(0, 32'd5000, bad);
    drive_event(32'd5200, 1'b1, 1'b0);
    vectors++;
    if (switch_req !== 1'b1 || pc_novo !== 32'd5200 || proc_atual !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL single_slot: req=%b pc=%0d idx=%0d want 1/5200/2", switch_req, pc_novo, proc_atual);
    end
    drive_ack(0, 32'd5200, bad);
    drive_event(32'd5300, 1'b0, 1'b1);
    vectors++;
    if (os_return !== 1'b1 || switch_req !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL final_exit: osr=%b req=%b busy=%b want 1/0/0", os_return, switch_req, busy);
    end
    step();
    vectors++;
    if (os_return !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL osr_pulse: osr=%b want 0", os_return);
    end
  endtask

  task automatic test_empty();
    int req_seen;
    do_reset();
    req_seen = 0;
    proc_valid = 4'b0000;
    start = 1'b1;
    step();
    start = 1'b0;
    if (switch_req === 1'b1) req_seen++;
    step();
    vectors++;
    if (os_return !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL empty_osr: osr=%b busy=%b want 1/0", os_return, busy);
    end
    if (switch_req === 1'b1) req_seen++;
    step();
    if (switch_req === 1'b1) req_seen++;
    vectors++;
    if (req_seen !== 0 || os_return !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL empty_noreq: req_seen=%0d osr=%b want 0/0", req_seen, os_return);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    drive_start(4'b0011, pack4(32'd4000, 32'd4100, 32'd0, 32'd0));
    drive_ack(0, 32'd4000, bad);
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (switch_req !== 1'b0 || preempcao !== 32'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_run: req=%b pre=%0d busy=%b want 0/0/0", switch_req, preempcao, busy);
    end
    #2 reset_n = 1'b1;
    step();
    drive_start(4'b0011, pack4(32'd4000, 32'd4100, 32'd0, 32'd0));
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (switch_req !== 1'b0 || busy !== 1'b0 || pc_novo !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_dispatch: req=%b busy=%b pc=%0d want 0/0/0", switch_req, busy, pc_novo);
    end
    #2 reset_n = 1'b1;
    step();
  endtask

  task automatic test_random();
    int bad;
    logic [N-1:0]    v;
    logic [N*32-1:0] e;
    logic [31:0]     pc;
    bit              tk, ex;
    for (int t = 0; t < 20; t++) begin
      do_reset();
      v = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) e[32*i +: 32] = 32'(3000 + $urandom_range(0, 6000));
      model_start(v, e);
      drive_start(v, e);
      for (int n = 0; n < 60 && exp_kind != 2; n++) begin
        if (exp_kind == 1) begin
          vectors++;
          if (switch_req !== 1'b1 || pc_novo !== exp_pc || proc_atual !== 2'(exp_idx)) begin
            miscompares++;
            $display("[TB] FAIL rnd_dispatch: req=%b pc=%0d idx=%0d want 1/%0d/%0d",
                     switch_req, pc_novo, proc_atual, exp_pc, exp_idx);
          end
          drive_ack($urandom_range(0, 2), exp_pc, bad);
          vectors++;
          if (bad !== 0 || preempcao !== 32'd1 || switch_req !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rnd_ack: bad=%0d pre=%0d req=%b want 0/1/0", bad, preempcao, switch_req);
          end
        end else begin
          vectors++;
          if (switch_req !== 1'b0 || preempcao !== 32'd1 || os_return !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rnd_run: req=%b pre=%0d osr=%b want 0/1/0", switch_req, preempcao, os_return);
          end
        end
        pc = 32'(2900 + $urandom_range(0, 3000));
        tk = ($urandom_range(0, 1) == 1);
        ex = ($urandom_range(0, 4) == 0);
        model_event(pc, tk, ex);
        drive_event(pc, tk, ex);
      end
      if (exp_kind == 2) begin
        vectors++;
        if (os_return !== 1'b1 || switch_req !== 1'b0 || busy !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL rnd_osr: osr=%b req=%b busy=%b want 1/0/0", os_return, switch_req, busy);
        end
      end
    end
  endtask

  initial begin
    $display("[TB] escalonador_rr bench starting");
    test_reset();
    test_dispatch();
    test_preempt();
    test_pending();
    test_exit();
    test_empty();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
